// File: rtl/staccato_pkg.sv
// Shared definitions for the rhythm-gate path: FSM encoding, default timing
// constants and the note counter width used by the display.
package staccato_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_PLAY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int DEF_MIN_GATE       = 1000;
  localparam int DEF_RELEASE_CYCLES = 2_500_000;
  localparam int DEF_PERIOD_W       = 18;
  localparam int NOTE_CNT_W         = 8;

  // Counter width for a terminal count of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave tone generator: latches the half-period on load and toggles sq
// every half-period while enabled; a zero half-period keeps sq low.
module tone_divider
  import staccato_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [PERIOD_W-1:0] half_period,
  output logic                sq
);

  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] tone_cnt_q;
  logic                sq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q   <= '0;
      tone_cnt_q <= '0;
      sq_q       <= 1'b0;
    end else if (load) begin
      period_q   <= half_period;
      tone_cnt_q <= '0;
      sq_q       <= (half_period != '0);
    end else if (en) begin
      if (period_q == '0) begin
        sq_q       <= 1'b0;
        tone_cnt_q <= '0;
      end else if (tone_cnt_q == period_q - PERIOD_W'(1)) begin
        sq_q       <= ~sq_q;
        tone_cnt_q <= '0;
      end else begin
        tone_cnt_q <= tone_cnt_q + PERIOD_W'(1);
      end
    end else begin
      sq_q       <= 1'b0;
      tone_cnt_q <= '0;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/staccato_gate_player.sv
// Turns each synchronised, glitch-filtered gate pulse into one square-wave note
// with a release tail, and counts the notes started.
module staccato_gate_player
  import staccato_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_GATE       = DEF_MIN_GATE,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int PERIOD_W       = DEF_PERIOD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gate_in,
  input  logic [PERIOD_W-1:0]   half_period,
  output logic                  audio_out,
  output logic                  playing,
  output logic [NOTE_CNT_W-1:0] note_count
);

  localparam int ARM_W = cnt_width(MIN_GATE);
  localparam int REL_W = cnt_width(RELEASE_CYCLES);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(MIN_GATE - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   gate_q;
  state_e                 state_q;
  logic [ARM_W-1:0]       arm_cnt_q;
  logic [REL_W-1:0]       rel_cnt_q;
  logic                   playing_q;
  logic [NOTE_CNT_W-1:0]  note_count_q;

  logic gate_s, rise, arm_done, rel_done, tone_load, tone_run;

  assign gate_s   = sync_q[SYNC_STAGES-1];
  assign rise     = gate_s & ~gate_q;
  assign arm_done = (state_q == ST_ARM) && gate_s && (arm_cnt_q == ARM_LAST);
  assign rel_done = (rel_cnt_q == REL_LAST);

  // The divider is steered by the next state so audio_out drops on the same
  // edge the FSM leaves the tail (timeout or retrigger).
  assign tone_load = arm_done;
  assign tone_run  = (state_q == ST_PLAY) ||
                     ((state_q == ST_RELEASE) && !rise && !rel_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      gate_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gate_in};
      gate_q <= gate_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      arm_cnt_q    <= '0;
      rel_cnt_q    <= '0;
      playing_q    <= 1'b0;
      note_count_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q   <= ST_ARM;
            arm_cnt_q <= '0;
          end
        end
        ST_ARM: begin
          if (!gate_s) begin
            state_q <= ST_IDLE;
          end else if (arm_done) begin
            state_q      <= ST_PLAY;
            playing_q    <= 1'b1;
            note_count_q <= note_count_q + NOTE_CNT_W'(1);
          end else begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
          end
        end
        ST_PLAY: begin
          if (!gate_s) begin
            state_q   <= ST_RELEASE;
            rel_cnt_q <= '0;
          end
        end
        ST_RELEASE: begin
          // A retrigger wins over a coinciding timeout so the new note is kept.
          if (rise) begin
            state_q   <= ST_ARM;
            arm_cnt_q <= '0;
            playing_q <= 1'b0;
          end else if (rel_done) begin
            state_q   <= ST_IDLE;
            playing_q <= 1'b0;
          end else begin
            rel_cnt_q <= rel_cnt_q + REL_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  tone_divider #(.PERIOD_W(PERIOD_W)) u_tone (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (tone_run),
    .load       (tone_load),
    .half_period(half_period),
    .sq         (audio_out)
  );

  assign playing    = playing_q;
  assign note_count = note_count_q;

endmodule

// File: tb/tb_staccato_gate_player.sv
// Bench for staccato_gate_player: hand vectors, corner sequences and random
// gate patterns, all checked against an elapsed-time model of note behaviour.
module tb_staccato_gate_player;
  localparam int S  = 2;
  localparam int MG = 4;
  localparam int RC = 20;
  localparam int PW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gate_in = 1'b0;
  logic [PW-1:0] half_period = '0;
  logic          audio_out, playing;
  logic [7:0]    note_count;

  staccato_gate_player #(.SYNC_STAGES(S), .MIN_GATE(MG), .RELEASE_CYCLES(RC), .PERIOD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .gate_in(gate_in), .half_period(half_period),
    .audio_out(audio_out), .playing(playing), .note_count(note_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases with start timestamps; the tone is derived from
  // the time elapsed since note start rather than from a running counter.
  localparam int P_IDLE = 0, P_ARMING = 1, P_SOUND = 2, P_TAIL = 3;
  int phase, t_edge, arm_t0, note_t0, fall_t, hp_l, notes;
  bit gin_hist [0:S];
  bit m_aud, m_play;

  task automatic model_reset();
    phase = P_IDLE; notes = 0; hp_l = 0; m_aud = 0; m_play = 0;
    for (int i = 0; i <= S; i++) gin_hist[i] = 0;
  endtask

  task automatic model_edge();
    bit gs, gq, rise;
    gs = gin_hist[S-1];
    gq = gin_hist[S];
    rise = gs && !gq;
    case (phase)
      P_IDLE:   if (rise) begin phase = P_ARMING; arm_t0 = t_edge; end
      P_ARMING: if (!gs) phase = P_IDLE;
                else if (t_edge - arm_t0 == MG) begin
                  phase = P_SOUND; note_t0 = t_edge; hp_l = int'(half_period);
                  notes = (notes + 1) % 256;
                end
      P_SOUND:  if (!gs) begin phase = P_TAIL; fall_t = t_edge; end
      default:  if (rise) begin phase = P_ARMING; arm_t0 = t_edge; end
                else if (t_edge - fall_t == RC) phase = P_IDLE;
    endcase
    m_play = (phase == P_SOUND) || (phase == P_TAIL);
    m_aud  = m_play && (hp_l > 0) && ((((t_edge - note_t0) / hp_l) % 2) == 0);
    for (int i = S; i > 0; i--) gin_hist[i] = gin_hist[i-1];
    gin_hist[0] = gate_in;
    t_edge++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_audio", {31'd0, audio_out}, {31'd0, m_aud});
    chk("model_playing", {31'd0, playing}, {31'd0, m_play});
    chk("model_count", {24'd0, note_count}, notes);
  endtask

  task automatic rtick();
    @(posedge clk);
    @(negedge clk);
    chk("rst_audio", {31'd0, audio_out}, 0);
    chk("rst_playing", {31'd0, playing}, 0);
    chk("rst_count", {24'd0, note_count}, 0);
  endtask

  task automatic hold(input bit g, input int hp, input int n);
    gate_in = g;
    half_period = PW'(hp);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic       gate;
    int         hp;
    int         cyc;
    logic       e_play;
    logic       e_aud;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 3, 3,  1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 3, 10, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 3, 6,  1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 3, 1,  1'b1, 1'b1, 8'd1};
    vecs[4]  = '{1'b1, 3, 3,  1'b1, 1'b0, 8'd1};
    vecs[5]  = '{1'b1, 3, 3,  1'b1, 1'b1, 8'd1};
    vecs[6]  = '{1'b1, 3, 27, 1'b1, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 3, 22, 1'b1, 1'b1, 8'd1};
    vecs[8]  = '{1'b0, 3, 1,  1'b0, 1'b0, 8'd1};
    vecs[9]  = '{1'b1, 0, 7,  1'b1, 1'b0, 8'd2};
    vecs[10] = '{1'b1, 5, 10, 1'b1, 1'b0, 8'd2};
    vecs[11] = '{1'b0, 5, 30, 1'b0, 1'b0, 8'd2};
    vecs[12] = '{1'b1, 5, 7,  1'b1, 1'b1, 8'd3};
    vecs[13] = '{1'b1, 5, 5,  1'b1, 1'b0, 8'd3};
    vecs[14] = '{1'b1, 5, 5,  1'b1, 1'b1, 8'd3};
    vecs[15] = '{1'b0, 5, 30, 1'b0, 1'b0, 8'd3};

    t_edge = 0;
    model_reset();

    // Reset held with the gate high: everything stays cleared.
    gate_in = 1'b1; half_period = PW'(3);
    for (int i = 0; i < 5; i++) rtick();
    gate_in = 1'b0;
    rtick();
    rst_n = 1'b1;
    hold(1'b0, 3, 5);

    for (int v = 0; v < 16; v++) begin
      hold(vecs[v].gate, vecs[v].hp, vecs[v].cyc);
      chk($sformatf("vec%0d_playing", v), {31'd0, playing}, {31'd0, vecs[v].e_play});
      chk($sformatf("vec%0d_audio", v), {31'd0, audio_out}, {31'd0, vecs[v].e_aud});
      chk($sformatf("vec%0d_count", v), {24'd0, note_count}, {24'd0, vecs[v].e_cnt});
    end

    // Staccato: each rise lands in the tail and retriggers.
    for (int b = 0; b < 3; b++) begin
      gate_in = 1'b1; half_period = PW'(3);
      for (int j = 0; j < 30; j++) begin
        tick();
        if (b > 0 && j == 3) begin
          chk("stacc_arm_audio", {31'd0, audio_out}, 0);
          chk("stacc_arm_playing", {31'd0, playing}, 0);
        end
      end
      hold(1'b0, 3, 10);
    end
    chk("stacc_count", {24'd0, note_count}, 6);
    hold(1'b0, 3, 30);

    // Reset in the middle of a note.
    hold(1'b1, 3, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_audio", {31'd0, audio_out}, 0);
    chk("midrst_playing", {31'd0, playing}, 0);
    chk("midrst_count", {24'd0, note_count}, 0);
    model_reset();
    rtick(); rtick();
    gate_in = 1'b0;
    rtick();
    rst_n = 1'b1;
    hold(1'b0, 3, 3);

    // 256 back-to-back notes wrap the counter.
    for (int n = 0; n < 256; n++) begin
      hold(1'b1, 2, 8);
      if (n == 0) chk("wrap_first", {24'd0, note_count}, 1);
      if (n == 254) chk("wrap_255", {24'd0, note_count}, 255);
      hold(1'b0, 2, 4);
    end
    chk("wrap_zero", {24'd0, note_count}, 0);
    hold(1'b0, 2, 30);

    // Random gate patterns and pitch changes.
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      len = $urandom_range(1, 45);
      gate_in = ~gate_in;
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 15) == 0) half_period = PW'($urandom_range(0, 7));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
